multicycle_ctrl: RTL and testbench

Control state machine for the multi-cycle CPU datapath. It drives the write-enable inputs of the datapath word latches (PC, IR, A/B, ALU-out, MDR), the register-file and data-memory write strobes, and the datapath mux selects. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. The block sits between the IR latch output and every `*_wren` input in the datapath.

---
 rtl/mctrl_pkg.sv | 57 +++++
 rtl/mctrl_decode.sv | 34 +++
 rtl/multicycle_ctrl.sv | 145 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control FSM: states, opcodes,
// funct codes, datapath mux selects and the one-hot instruction class.
package mctrl_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CODE_W  = 6;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [CODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [CODE_W-1:0] OP_J     = 6'h02;
    localparam logic [CODE_W-1:0] OP_JAL   = 6'h03;
    localparam logic [CODE_W-1:0] OP_BNE   = 6'h05;
    localparam logic [CODE_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [CODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [CODE_W-1:0] OP_SW    = 6'h2B;

    localparam logic [CODE_W-1:0] FN_JR    = 6'h08;
    localparam logic [CODE_W-1:0] FN_ADD   = 6'h20;
    localparam logic [CODE_W-1:0] FN_SUB   = 6'h22;
    localparam logic [CODE_W-1:0] FN_SLT   = 6'h2A;

    localparam logic [SEL_W-1:0] PC_SRC_PC4    = 2'd0;
    localparam logic [SEL_W-1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [SEL_W-1:0] PC_SRC_REGA   = 2'd3;

    localparam logic [SEL_W-1:0] ALUB_B    = 2'd0;
    localparam logic [SEL_W-1:0] ALUB_FOUR = 2'd1;
    localparam logic [SEL_W-1:0] ALUB_SEXT = 2'd2;
    localparam logic [SEL_W-1:0] ALUB_ZEXT = 2'd3;

    localparam logic [SEL_W-1:0] REG_DST_RT = 2'd0;
    localparam logic [SEL_W-1:0] REG_DST_RD = 2'd1;
    localparam logic [SEL_W-1:0] REG_DST_RA = 2'd2;

    // Exactly one field is set for any opcode/funct combination.
    typedef struct packed {
        logic rtype;
        logic jr;
        logic lw;
        logic sw;
        logic j;
        logic jal;
        logic bne;
        logic xori;
        logic illegal;
    } iclass_t;

endpackage

// File: rtl/mctrl_decode.sv
// Combinational opcode/funct classifier producing a one-hot instruction class.
module mctrl_decode
    import mctrl_pkg::*;
#(
    parameter int unsigned OPW = 6
) (
    input  logic [OPW-1:0] opcode_i,
    input  logic [OPW-1:0] funct_i,
    output iclass_t        cls_o
);

    always_comb begin
        cls_o = '0;
        case (opcode_i)
            OPW'(OP_RTYPE): begin
                case (funct_i)
                    OPW'(FN_ADD),
                    OPW'(FN_SUB),
                    OPW'(FN_SLT): cls_o.rtype   = 1'b1;
                    OPW'(FN_JR):  cls_o.jr      = 1'b1;
                    default:      cls_o.illegal = 1'b1;
                endcase
            end
            OPW'(OP_LW):   cls_o.lw      = 1'b1;
            OPW'(OP_SW):   cls_o.sw      = 1'b1;
            OPW'(OP_J):    cls_o.j       = 1'b1;
            OPW'(OP_JAL):  cls_o.jal     = 1'b1;
            OPW'(OP_BNE):  cls_o.bne     = 1'b1;
            OPW'(OP_XORI): cls_o.xori    = 1'b1;
            default:       cls_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing of datapath strobes.
// Define MCTRL_MEM_WAIT_EN to add a mem_ready input that stretches the MEM state.
module multicycle_ctrl
    import mctrl_pkg::*;
#(
    parameter int unsigned OPW = 6
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MCTRL_MEM_WAIT_EN
    input  logic             mem_ready,
`endif
    input  logic [OPW-1:0]   opcode,
    input  logic [OPW-1:0]   funct,
    input  logic             zero,
    output logic             pc_wren,
    output logic             ir_wren,
    output logic             ab_wren,
    output logic             aluout_wren,
    output logic             mdr_wren,
    output logic             reg_wren,
    output logic             mem_wren,
    output logic [SEL_W-1:0] pc_src,
    output logic [SEL_W-1:0] alu_src_b,
    output logic [SEL_W-1:0] reg_dst,
    output logic             mem_to_reg,
    output logic             instr_done,
    output logic             illegal,
    output logic [STATE_W-1:0] state
);

    state_e  state_q, state_d;
    iclass_t cls;
    logic    mem_go_c;

    mctrl_decode #(.OPW(OPW)) u_decode (
        .opcode_i (opcode),
        .funct_i  (funct),
        .cls_o    (cls)
    );

`ifdef MCTRL_MEM_WAIT_EN
    assign mem_go_c = mem_ready;
`else
    assign mem_go_c = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and strobes; everything stays 0 while reset is high.
    always_comb begin
        state_d     = state_q;
        pc_wren     = 1'b0;
        ir_wren     = 1'b0;
        ab_wren     = 1'b0;
        aluout_wren = 1'b0;
        mdr_wren    = 1'b0;
        reg_wren    = 1'b0;
        mem_wren    = 1'b0;
        pc_src      = PC_SRC_PC4;
        alu_src_b   = ALUB_B;
        reg_dst     = REG_DST_RT;
        mem_to_reg  = 1'b0;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    ir_wren = 1'b1;
                    pc_wren = 1'b1;
                    pc_src  = PC_SRC_PC4;
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    ab_wren = 1'b1;
                    state_d = S_EXEC;
                    if (cls.j || cls.jal) begin
                        pc_wren = 1'b1;
                        pc_src  = PC_SRC_JUMP;
                        state_d = S_FETCH;
                    end
                    if (cls.jal) begin
                        reg_wren = 1'b1;
                        reg_dst  = REG_DST_RA;
                    end
                    if (cls.jr) begin
                        pc_wren = 1'b1;
                        pc_src  = PC_SRC_REGA;
                        state_d = S_FETCH;
                    end
                    // PC already advanced in FETCH, so the bad instruction is skipped.
                    if (cls.illegal) begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_EXEC: begin
                    aluout_wren = 1'b1;
                    if (cls.lw || cls.sw) begin
                        alu_src_b = ALUB_SEXT;
                    end else if (cls.xori) begin
                        alu_src_b = ALUB_ZEXT;
                    end
                    if (cls.bne) begin
                        pc_wren = !zero;
                        pc_src  = PC_SRC_BRANCH;
                        state_d = S_FETCH;
                    end else if (cls.lw || cls.sw) begin
                        state_d = S_MEM;
                    end else if (cls.rtype || cls.xori) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_MEM: begin
                    mdr_wren = cls.lw;
                    mem_wren = cls.sw;
                    if (mem_go_c || !(cls.lw || cls.sw)) begin
                        state_d = cls.lw ? S_WB : S_FETCH;
                    end
                end
                S_WB: begin
                    reg_wren   = 1'b1;
                    reg_dst    = cls.rtype ? REG_DST_RD : REG_DST_RT;
                    mem_to_reg = cls.lw;
                    state_d    = S_FETCH;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
            instr_done = (state_d == S_FETCH);
        end
    end

    assign state = reset ? STATE_W'(0) : STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver queues hand-built per-cycle
// expectations, a negedge monitor pops one per cycle and compares all outputs.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [2:0] state;
        logic       pc_wren;
        logic       ir_wren;
        logic       ab_wren;
        logic       aluout_wren;
        logic       mdr_wren;
        logic       reg_wren;
        logic       mem_wren;
        logic [1:0] pc_src;
        logic [1:0] alu_src_b;
        logic [1:0] reg_dst;
        logic       mem_to_reg;
        logic       instr_done;
        logic       illegal;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
`ifdef MCTRL_MEM_WAIT_EN
    logic       mem_ready = 1'b1;
`endif
    logic       pc_wren, ir_wren, ab_wren, aluout_wren, mdr_wren, reg_wren, mem_wren;
    logic [1:0] pc_src, alu_src_b, reg_dst;
    logic       mem_to_reg, instr_done, illegal;
    logic [2:0] state;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk         (clk),
        .reset       (reset),
`ifdef MCTRL_MEM_WAIT_EN
        .mem_ready   (mem_ready),
`endif
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .pc_wren     (pc_wren),
        .ir_wren     (ir_wren),
        .ab_wren     (ab_wren),
        .aluout_wren (aluout_wren),
        .mdr_wren    (mdr_wren),
        .reg_wren    (reg_wren),
        .mem_wren    (mem_wren),
        .pc_src      (pc_src),
        .alu_src_b   (alu_src_b),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .instr_done  (instr_done),
        .illegal     (illegal),
        .state       (state)
    );

    exp_t        exp_q[$];
    string       name_q[$];
    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    exp_t        mon_exp, mon_act;
    string       mon_name;

    function automatic exp_t blank(input logic [2:0] st);
        exp_t r;
        r = '0;
        r.state = st;
        return r;
    endfunction

    function automatic exp_t fetch_exp();
        exp_t r;
        r = blank(3'd0);
        r.pc_wren = 1'b1;
        r.ir_wren = 1'b1;
        return r;
    endfunction

    function automatic exp_t decode_exp();
        exp_t r;
        r = blank(3'd1);
        r.ab_wren = 1'b1;
        return r;
    endfunction

    task automatic push(input string nm, input exp_t v);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One output vector checked per cycle whenever an expectation is pending.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = '{state, pc_wren, ir_wren, ab_wren, aluout_wren, mdr_wren,
                         reg_wren, mem_wren, pc_src, alu_src_b, reg_dst,
                         mem_to_reg, instr_done, illegal};
            n_vec++;
            if (mon_act !== mon_exp) begin
                n_miss++;
                $display("FAIL %s: got %05h (state=%0d) expected %05h (state=%0d)",
                         mon_name, mon_act, mon_act.state, mon_exp, mon_exp.state);
            end
        end
    end

    // R-type / XORI: F, D, E, WB.
    task automatic ins_alu(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input logic [1:0] srcb, input logic [1:0] rdst, input logic z);
        exp_t x;
        push({nm, " F"}, fetch_exp());
        push({nm, " D"}, decode_exp());
        x = blank(3'd2); x.aluout_wren = 1'b1; x.alu_src_b = srcb;
        push({nm, " E"}, x);
        x = blank(3'd4); x.reg_wren = 1'b1; x.reg_dst = rdst; x.instr_done = 1'b1;
        push({nm, " W"}, x);
        opcode = op; funct = fn; zero = z;
        run(4);
    endtask

    // Two-cycle instructions completing in DECODE.
    task automatic ins_short(input string nm, input logic [5:0] op, input logic [5:0] fn,
                             input logic pcw, input logic [1:0] psrc, input logic regw,
                             input logic [1:0] rdst, input logic ill);
        exp_t x;
        push({nm, " F"}, fetch_exp());
        x = decode_exp(); x.pc_wren = pcw; x.pc_src = psrc; x.reg_wren = regw;
        x.reg_dst = rdst; x.illegal = ill; x.instr_done = 1'b1;
        push({nm, " D"}, x);
        opcode = op; funct = fn;
        run(2);
    endtask

    task automatic ins_bne(input string nm, input logic z, input logic pcw);
        exp_t x;
        push({nm, " F"}, fetch_exp());
        push({nm, " D"}, decode_exp());
        x = blank(3'd2); x.aluout_wren = 1'b1; x.pc_wren = pcw; x.pc_src = 2'd1;
        x.instr_done = 1'b1;
        push({nm, " E"}, x);
        opcode = 6'h05; funct = 6'h2A; zero = z;
        run(3);
    endtask

    task automatic ins_lw(input string nm, input logic [5:0] fn);
        exp_t x;
        push({nm, " F"}, fetch_exp());
        push({nm, " D"}, decode_exp());
        x = blank(3'd2); x.aluout_wren = 1'b1; x.alu_src_b = 2'd2;
        push({nm, " E"}, x);
        x = blank(3'd3); x.mdr_wren = 1'b1;
        push({nm, " M"}, x);
        x = blank(3'd4); x.reg_wren = 1'b1; x.mem_to_reg = 1'b1; x.instr_done = 1'b1;
        push({nm, " W"}, x);
        opcode = 6'h23; funct = fn;
        run(5);
    endtask

    task automatic ins_sw(input string nm);
        exp_t x;
        push({nm, " F"}, fetch_exp());
        push({nm, " D"}, decode_exp());
        x = blank(3'd2); x.aluout_wren = 1'b1; x.alu_src_b = 2'd2;
        push({nm, " E"}, x);
        x = blank(3'd3); x.mem_wren = 1'b1; x.instr_done = 1'b1;
        push({nm, " M"}, x);
        opcode = 6'h2B; funct = 6'h20;
        run(4);
    endtask

    initial begin : driver
        exp_t x;
        // Two reset cycles: everything forced to zero.
        @(posedge clk); #1;
        push("RST0", blank(3'd0));
        push("RST1", blank(3'd0));
        run(2);
        reset = 1'b0;

        ins_alu("ADD",  6'h00, 6'h20, 2'd0, 2'd1, 1'b1);
        ins_alu("SUB",  6'h00, 6'h22, 2'd0, 2'd1, 1'b0);
        ins_alu("SLT",  6'h00, 6'h2A, 2'd0, 2'd1, 1'b0);
        ins_alu("XORI", 6'h0E, 6'h08, 2'd3, 2'd0, 1'b0);
        ins_lw("LW", 6'h08);
        ins_sw("SW");
        ins_bne("BNE_Z1", 1'b1, 1'b0);
        ins_bne("BNE_Z0", 1'b0, 1'b1);
        zero = 1'b0;
        ins_short("J",      6'h02, 6'h00, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        ins_short("JAL",    6'h03, 6'h00, 1'b1, 2'd2, 1'b1, 2'd2, 1'b0);
        ins_short("JR",     6'h00, 6'h08, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
        ins_short("OP3F",   6'h3F, 6'h20, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        ins_short("FN21",   6'h00, 6'h21, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);

        // Reset for two cycles while an LW sits in MEM.
        push("LWR F", fetch_exp());
        push("LWR D", decode_exp());
        x = blank(3'd2); x.aluout_wren = 1'b1; x.alu_src_b = 2'd2;
        push("LWR E", x);
        opcode = 6'h23; funct = 6'h00;
        run(3);
        reset = 1'b1;
        push("LWR RST0", blank(3'd0));
        push("LWR RST1", blank(3'd0));
        run(2);
        reset = 1'b0;
        ins_alu("ADD2", 6'h00, 6'h20, 2'd0, 2'd1, 1'b0);

`ifdef MCTRL_MEM_WAIT_EN
        // LW with mem_ready low for three MEM cycles: 8 cycles total.
        push("LWW F", fetch_exp());
        push("LWW D", decode_exp());
        x = blank(3'd2); x.aluout_wren = 1'b1; x.alu_src_b = 2'd2;
        push("LWW E", x);
        x = blank(3'd3); x.mdr_wren = 1'b1;
        push("LWW M0", x);
        push("LWW M1", x);
        push("LWW M2", x);
        push("LWW M3", x);
        x = blank(3'd4); x.reg_wren = 1'b1; x.mem_to_reg = 1'b1; x.instr_done = 1'b1;
        push("LWW W", x);
        opcode = 6'h23; funct = 6'h00; mem_ready = 1'b0;
        run(6);
        mem_ready = 1'b1;
        run(2);
        // SW with one wait cycle: done only when mem_ready rises.
        push("SWW F", fetch_exp());
        push("SWW D", decode_exp());
        x = blank(3'd2); x.aluout_wren = 1'b1; x.alu_src_b = 2'd2;
        push("SWW E", x);
        x = blank(3'd3); x.mem_wren = 1'b1;
        push("SWW M0", x);
        x.instr_done = 1'b1;
        push("SWW M1", x);
        opcode = 6'h2B; mem_ready = 1'b0;
        run(4);
        mem_ready = 1'b1;
        run(1);
`endif

        run(1);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
